// File: rtl/clock_reset_gen.sv
// Board clock divider and stretched system reset generator.
// Produces the slow system clock clk from the board clock CLK and an
// active-low reset rst_n that releases synchronously to clk after a
// programmable number of clk rising edges.
module clock_reset_gen #(
  parameter int SLOW       = 0,
  parameter int RESET_HOLD = 16
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic rst_n
);

  localparam logic [7:0] HOLD = 8'(RESET_HOLD);

  logic [1:0] r_sync;
  logic [7:0] r_hold;
  logic       r_rst_n;
  logic       w_run;
  logic       w_clk_rise;
  logic       w_clk_fall;

  // Two-flop synchronizer: RESET release reaches the core two CLK edges later.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], 1'b1};
  end

  assign w_run = r_sync[1];

  generate
    if (SLOW == 0) begin : g_nodiv
      // Undivided: every CLK edge is both a clk rising edge and an update
      // point for rst_n.
      assign clk        = CLK;
      assign w_clk_rise = w_run;
      assign w_clk_fall = w_run;
    end else begin : g_div
      logic [SLOW:0] r_div;

      // Free-running divider, held at zero until the synchronized release.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)     r_div <= '0;
        else if (!w_run) r_div <= '0;
        else            r_div <= r_div + 1'b1;
      end

      // clk comes straight off the MSB so it carries no combinational glitches.
      assign clk = r_div[SLOW];
      // Edge where div goes 2^SLOW-1 -> 2^SLOW (clk rises).
      assign w_clk_rise = w_run & ~r_div[SLOW] & (&r_div[SLOW-1:0]);
      // Edge where div wraps to 0 (clk falls).
      assign w_clk_fall = w_run & (&r_div);
    end
  endgenerate

  // Hold counter: counts clk rising edges up to RESET_HOLD, then saturates.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                           r_hold <= 8'd0;
    else if (w_clk_rise && r_hold < HOLD) r_hold <= r_hold + 8'd1;
  end

  // rst_n releases on a clk falling edge so it is stable for half a period
  // before the first clk rising edge that sees it high.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                          r_rst_n <= 1'b0;
    else if (w_clk_fall && r_hold == HOLD) r_rst_n <= 1'b1;
  end

  assign rst_n = r_rst_n;

endmodule

// File: tb/tb_clock_reset_gen.sv
// Self-checking bench for clock_reset_gen: three parameterisations share one
// board clock and reset; outputs are compared every CLK cycle against an
// arithmetic model based on the number of CLK edges since RESET rose.
module tb_clock_reset_gen;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic clk_a, rst_a;   // SLOW=2, RESET_HOLD=4
  logic clk_b, rst_b;   // SLOW=0, RESET_HOLD=3
  logic clk_c, rst_c;   // SLOW=3, RESET_HOLD=16

  int total = 0;
  int bad   = 0;
  int k     = 0;        // CLK rising edges since RESET was released

  clock_reset_gen #(.SLOW(2), .RESET_HOLD(4)) u_a (
    .CLK(CLK), .RESET(RESET), .clk(clk_a), .rst_n(rst_a));
  clock_reset_gen #(.SLOW(0), .RESET_HOLD(3)) u_b (
    .CLK(CLK), .RESET(RESET), .clk(clk_b), .rst_n(rst_b));
  clock_reset_gen #(.SLOW(3), .RESET_HOLD(16)) u_c (
    .CLK(CLK), .RESET(RESET), .clk(clk_c), .rst_n(rst_c));

  always #5 CLK = ~CLK;

  // Divided clock after kk edges: counting begins 2 edges after release,
  // each half period lasts 2^s CLK cycles, starting low.
  function automatic logic m_clk(int s, int kk);
    if (kk < 2) return 1'b0;
    return logic'(((kk - 2) >> s) & 1);
  endfunction

  // rst_n: for s>0 it rises at the clk fall that ends the h-th clk period;
  // undivided it rises one edge after h counted edges.
  function automatic logic m_rst(int s, int h, int kk);
    if (s == 0) return logic'(kk >= h + 3);
    return logic'(kk >= 2 + (h << (s + 1)));
  endfunction

  task automatic chk(string tag, logic obs, logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b k=%0d t=%0t", tag, obs, expv, k, $time);
    end
  endtask

  task automatic chk_int(string tag, int obs, int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("clk_a", clk_a, m_clk(2, k));
    chk("rst_a", rst_a, m_rst(2, 4, k));
    chk("clk_b", clk_b, CLK);
    chk("rst_b", rst_b, m_rst(0, 3, k));
    chk("clk_c", clk_c, m_clk(3, k));
    chk("rst_c", rst_c, m_rst(3, 16, k));
  endtask

  // One CLK cycle: advance the model at the edge, sample 1 time unit later.
  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      if (RESET) k++;
      #1;
      check_all();
    end
  endtask

  // Asynchronous assertion 3 units after an edge; outputs must drop before
  // any further CLK edge.
  task automatic assert_reset();
    @(posedge CLK); #3;
    RESET = 1'b0;
    k = 0;
    #1;
    check_all();
  endtask

  task automatic release_reset();
    @(posedge CLK); #3;
    RESET = 1'b1;
  endtask

  int highs, rises;
  logic prev;

  initial begin
    // Reset held for 10 cycles: clk and rst_n low throughout.
    RESET = 1'b0;
    step(10);
    $display("reset hold 10 cycles: clk_a=%0b rst_a=%0b", clk_a, rst_a);

    // Release and run through the stretch of the SLOW=2 / SLOW=0 instances.
    release_reset();
    step(40);
    $display("release+40: rst_a=%0b rst_b=%0b k=%0d", rst_a, rst_b, k);

    // Free run: 100 periods of clk_a, measure high time and rising edges.
    highs = 0; rises = 0; prev = clk_a;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (clk_a) highs++;
      if (clk_a && !prev) rises++;
      prev = clk_a;
    end
    chk_int("high_cycles_a", highs, 400);
    chk_int("rises_a", rises, 100);
    $display("free run 800 cycles: highs=%0d rises=%0d", highs, rises);

    // Short pulse while clk_a is high and rst_n already released.
    while (!(clk_a && rst_a && m_clk(2, k + 1))) step(1);
    assert_reset();
    step(1);
    release_reset();
    step(60);
    $display("async pulse restart: rst_a=%0b k=%0d", rst_a, k);

    // Reassert mid-stretch (hold counter of instance a at 2), then restart.
    assert_reset();
    release_reset();
    step(16);
    assert_reset();
    step(2);
    release_reset();
    step(50);
    $display("mid-stretch restart: rst_a=%0b k=%0d", rst_a, k);

    // Randomised run lengths and reset pulse widths.
    for (int it = 0; it < 20; it++) begin
      int run_len, rst_len;
      run_len = int'($urandom_range(1, 400));
      rst_len = int'($urandom_range(0, 5));
      step(run_len);
      assert_reset();
      step(rst_len);
      release_reset();
      $display("random iter %0d: run=%0d reset=%0d", it, run_len, rst_len);
    end
    step(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
